// File: rtl/synthesijer_fconv_f2d.sv
// Fully pipelined binary32 -> binary64 converter, 3-cycle latency, one operand per cycle.
// Stage 1 classifies the operand, stage 2 counts fraction leading zeros, stage 3 assembles the double.
module synthesijer_fconv_f2d (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] a,
  input  logic        nd,
  output logic [63:0] result,
  output logic        valid
);

  localparam int STAGES = 3;

  typedef enum logic [2:0] {
    C_ZERO = 3'd0,
    C_NORM = 3'd1,
    C_SUB  = 3'd2,
    C_INF  = 3'd3,
    C_NAN  = 3'd4
  } cls_t;

  logic [STAGES:1] vld_pipe;

  // stage 1
  logic        s1_s;
  logic [7:0]  s1_e;
  logic [22:0] s1_m;
  cls_t        s1_cls;
  cls_t        cls_d;

  // stage 2
  logic        s2_s;
  logic [7:0]  s2_e;
  logic [22:0] s2_m;
  cls_t        s2_cls;
  logic [4:0]  s2_lz;
  logic [4:0]  lz_d;

  logic [63:0] res_d;
  logic [22:0] sub_frac;

  always_comb begin
    cls_d = C_NORM;
    if (a[30:23] == 8'd0)
      cls_d = (a[22:0] == 23'd0) ? C_ZERO : C_SUB;
    else if (a[30:23] == 8'hff)
      cls_d = (a[22:0] == 23'd0) ? C_INF : C_NAN;
  end

  // Last hit wins, so the highest set bit sets lz; m==0 never reaches the subnormal path.
  always_comb begin
    lz_d = 5'd0;
    for (int i = 0; i < 23; i++)
      if (s1_m[i]) lz_d = 5'(22 - i);
  end

  always_comb begin
    sub_frac = s2_m << (s2_lz + 5'd1);
    res_d    = {s2_s, 63'd0};
    case (s2_cls)
      C_ZERO:  res_d = {s2_s, 63'd0};
      C_NORM:  res_d = {s2_s, {3'b000, s2_e} + 11'd896, s2_m, 29'd0};
      C_SUB:   res_d = {s2_s, 11'd896 - {6'd0, s2_lz}, sub_frac, 29'd0};
      C_INF:   res_d = {s2_s, 11'h7ff, 52'd0};
      default: res_d = {s2_s, 11'h7ff, 1'b1, s2_m[21:0], 29'd0};
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe <= '0;
      s1_s     <= 1'b0;
      s1_e     <= 8'd0;
      s1_m     <= 23'd0;
      s1_cls   <= C_ZERO;
      s2_s     <= 1'b0;
      s2_e     <= 8'd0;
      s2_m     <= 23'd0;
      s2_cls   <= C_ZERO;
      s2_lz    <= 5'd0;
      result   <= 64'd0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-1:1], nd};
      // data registers only move with a live token, so a idle-cycle a changes nothing
      if (nd) begin
        s1_s   <= a[31];
        s1_e   <= a[30:23];
        s1_m   <= a[22:0];
        s1_cls <= cls_d;
      end
      if (vld_pipe[1]) begin
        s2_s   <= s1_s;
        s2_e   <= s1_e;
        s2_m   <= s1_m;
        s2_cls <= s1_cls;
        s2_lz  <= lz_d;
      end
      if (vld_pipe[2])
        result <= res_d;
    end
  end

  assign valid = vld_pipe[STAGES];

endmodule
